// File: rtl/m2s_drain_master.sv
// m2s_drain_master
// Avalon-MM read master that drains a 16-bit buffer read slave (read latency 1,
// waitrequest while empty) and re-emits the words as an Avalon-ST source.
// A small output FIFO absorbs the read latency so one word per clock can be
// sustained.
//
// Optional feature: define M2S_DRAIN_LENGTH_LIMIT_EN to add the length/done
// ports. A transfer of 'length' words is then run per enable session. Without
// the macro, reads continue for as long as enable is high.

module m2s_drain_master #(
  parameter int DATA_W    = 16,
  parameter int OUT_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic              wrclock,
  input  logic              reset_n,
  input  logic              enable,
  output logic              avm_read,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic [CNT_W-1:0]  word_count
`ifdef M2S_DRAIN_LENGTH_LIMIT_EN
  ,
  input  logic [CNT_W-1:0]  length,
  output logic              done
`endif
);

  // Pointer width and occupancy width (occupancy must be able to hold OUT_DEPTH).
  localparam int AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(OUT_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              hold_q, hold_d;          // read pending under waitrequest
  logic              inflight_q, inflight_d;  // accepted last cycle, data arrives now
  logic [DATA_W-1:0] mem_q [OUT_DEPTH];
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     occ_q, occ_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  word_count_q, word_count_d;

  logic              push_s;
  logic              pop_s;
  logic              room_s;
  logic              issue_ok_s;
  logic              accept_s;
  logic              start_s;

`ifdef M2S_DRAIN_LENGTH_LIMIT_EN
  logic [CNT_W-1:0]  length_q, length_d;   // words requested this session
  logic [CNT_W-1:0]  rem_q, rem_d;         // read requests still allowed
  logic [CNT_W-1:0]  xfer_q, xfer_d;       // stream transfers this session
  logic              done_q, done_d;
`endif

  // Output FIFO handshake terms and the read-issue decision.
  always_comb begin
    push_s     = inflight_q;
    pop_s      = valid_q & st_ready;
    // Room for one more request counts both stored and in-flight words.
    room_s     = ((occ_q + CW'(inflight_q)) < DEPTH_C);
    start_s    = (state_q == ST_IDLE) & enable;
`ifdef M2S_DRAIN_LENGTH_LIMIT_EN
    issue_ok_s = enable & (state_q == ST_RUN) & room_s & (rem_q != '0);
`else
    issue_ok_s = enable & (state_q == ST_RUN) & room_s;
`endif
    // A stalled request is held unconditionally; enable only gates new ones.
    avm_read   = hold_q | issue_ok_s;
    accept_s   = avm_read & ~avm_waitrequest;
    hold_d     = avm_read & avm_waitrequest;
    inflight_d = accept_s;
  end

  // Next-state for the output FIFO pointers, occupancy and transfer counter.
  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    occ_d        = occ_q;
    word_count_d = word_count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d     = rd_ptr_q + AW'(1);
      word_count_d = word_count_q + CNT_W'(1);
    end else begin
      rd_ptr_d     = rd_ptr_q;
      word_count_d = word_count_q;
    end
    case ({push_s, pop_s})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase
    valid_d = (occ_d != '0);
  end

  // FSM next state and per-session length bookkeeping.
  always_comb begin
    state_d = state_q;
`ifdef M2S_DRAIN_LENGTH_LIMIT_EN
    length_d = length_q;
    xfer_d   = xfer_q + CNT_W'(pop_s);
    if (start_s) begin
      length_d = length;
      rem_d    = length;
      xfer_d   = '0;
    end else if (accept_s) begin
      rem_d    = rem_q - CNT_W'(1);
    end else begin
      rem_d    = rem_q;
    end
`endif
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
`ifdef M2S_DRAIN_LENGTH_LIMIT_EN
        if (xfer_q == length_q) begin
          state_d = ST_DONE;
        end else if (~enable & ~avm_read) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
`else
        // Data already in flight keeps draining to the stream from IDLE.
        if (~enable & ~avm_read) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
`endif
      end
`ifdef M2S_DRAIN_LENGTH_LIMIT_EN
      ST_DONE: begin
        if (~enable) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
`ifdef M2S_DRAIN_LENGTH_LIMIT_EN
    done_d = (state_d == ST_DONE);
`endif
  end

  // Control registers: FSM, read handshake, FIFO pointers and counters.
  always_ff @(posedge wrclock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      hold_q       <= 1'b0;
      inflight_q   <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      occ_q        <= '0;
      valid_q      <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      inflight_q   <= inflight_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      occ_q        <= occ_d;
      valid_q      <= valid_d;
      word_count_q <= word_count_d;
    end
  end

  // Output FIFO storage; the read data arrives the cycle after acceptance.
  always_ff @(posedge wrclock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < OUT_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= avm_readdata;
      end
    end
  end

`ifdef M2S_DRAIN_LENGTH_LIMIT_EN
  // Length-limit registers: sampled length, remaining requests, transfers, done.
  always_ff @(posedge wrclock or negedge reset_n) begin
    if (!reset_n) begin
      length_q <= '0;
      rem_q    <= '0;
      xfer_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      length_q <= length_d;
      rem_q    <= rem_d;
      xfer_q   <= xfer_d;
      done_q   <= done_d;
    end
  end

  assign done = done_q;
`endif

  assign st_valid   = valid_q;
  assign st_data    = mem_q[rd_ptr_q];
  assign word_count = word_count_q;

endmodule

// File: tb/tb_m2s_drain_master.sv
// Testbench for m2s_drain_master: a buffer model acts as the Avalon-MM slave,
// accepted words go into a scoreboard queue, and a monitor compares every
// stream transfer against it while also checking the request rules.
module tb_m2s_drain_master;

  localparam int DEPTH = 4;

  logic        wrclock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        avm_read;
  logic [15:0] avm_readdata;
  logic        avm_waitrequest;
  logic [15:0] st_data;
  logic        st_valid;
  logic        st_ready;
  logic [15:0] word_count;
`ifdef M2S_DRAIN_LENGTH_LIMIT_EN
  logic [15:0] length;
  logic        done;
`endif

  m2s_drain_master #(.DATA_W(16), .OUT_DEPTH(DEPTH), .CNT_W(16)) dut (
    .wrclock        (wrclock),
    .reset_n        (reset_n),
    .enable         (enable),
    .avm_read       (avm_read),
    .avm_readdata   (avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .st_data        (st_data),
    .st_valid       (st_valid),
    .st_ready       (st_ready),
    .word_count     (word_count)
`ifdef M2S_DRAIN_LENGTH_LIMIT_EN
    ,
    .length         (length),
    .done           (done)
`endif
  );

  always #5 wrclock = ~wrclock;

  logic [15:0] buf_q[$];   // words the buffer slave still holds
  logic [15:0] exp_q[$];   // scoreboard: accepted, not yet streamed
  int          xc_q[$];    // cycles of recorded stream transfers

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_total = 0;
  int xfer_total = 0;
  bit en_v = 1'b0;
  int rdy_pct = 100;
  int stall_pct = 0;
  logic [15:0] length_v = 16'hFFFF;
  logic [15:0] pend_data = 16'h0000;
  bit pend_v = 1'b0;
  bit prev_hold = 1'b0;
  bit prev_stall = 1'b0;
  logic [15:0] prev_data = 16'h0000;
  bit mark_acc = 1'b0;
  bit mark_val = 1'b0;
  bit rec_xfer = 1'b0;
  int first_acc_cyc = 0;
  int first_val_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Buffer slave model: drives inputs each cycle and records accepted reads.
  always @(negedge wrclock) begin
    logic [15:0] w;
    cyc++;
    avm_readdata    = pend_v ? pend_data : 16'($urandom);
    pend_v          = 1'b0;
    avm_waitrequest = (buf_q.size() == 0) || ($urandom_range(99) < stall_pct);
    enable          = en_v;
    st_ready        = ($urandom_range(99) < rdy_pct);
`ifdef M2S_DRAIN_LENGTH_LIMIT_EN
    length          = length_v;
`endif
    #1;
    if (reset_n) begin
      if (prev_hold) chk("hold_rule", {31'd0, avm_read}, 32'd1);
      if (avm_read && !prev_hold) chk("issue_needs_enable", {31'd0, enable}, 32'd1);
      if (avm_read && !avm_waitrequest) begin
        w = buf_q.pop_front();
        exp_q.push_back(w);
        pend_data = w;
        pend_v = 1'b1;
        acc_total++;
        chk("room_rule", {31'd0, (acc_total - xfer_total) <= DEPTH}, 32'd1);
        if (mark_acc) begin
          first_acc_cyc = cyc;
          mark_acc = 1'b0;
        end
      end
      prev_hold = avm_read & avm_waitrequest;
    end else begin
      prev_hold = 1'b0;
    end
  end

  // Stream monitor: pops the scoreboard on every transfer and compares.
  always @(negedge wrclock) begin
    logic [15:0] e;
    #2;
    if (reset_n) begin
      chk("word_count", {16'd0, word_count}, {16'd0, 16'(xfer_total)});
      if (prev_stall) begin
        chk("stall_valid", {31'd0, st_valid}, 32'd1);
        chk("stall_data", {16'd0, st_data}, {16'd0, prev_data});
      end
      if (mark_val && st_valid) begin
        first_val_cyc = cyc;
        mark_val = 1'b0;
      end
      if (st_valid && st_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {16'd0, st_data}, 32'hFFFFFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("st_data", {16'd0, st_data}, {16'd0, e});
        end
        xfer_total++;
        if (rec_xfer) xc_q.push_back(cyc);
      end
      prev_stall = st_valid & ~st_ready;
      prev_data  = st_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge wrclock);
      #3;
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (!(buf_q.size() == 0 && exp_q.size() == 0 && !st_valid) && n < budget) begin
      step(1);
      n++;
    end
    chk("drain_timeout", {31'd0, (n < budget)}, 32'd1);
  endtask

  initial begin
    int a0, x0;
    reset_n = 1'b0;
    step(3);
    chk("rst_avm_read", {31'd0, avm_read}, 32'd0);
    chk("rst_st_valid", {31'd0, st_valid}, 32'd0);
    chk("rst_st_data", {16'd0, st_data}, 32'd0);
    chk("rst_word_count", {16'd0, word_count}, 32'd0);
    reset_n = 1'b1;
    step(2);

    // Preloaded 1..8 streamed back to back.
    for (int i = 1; i <= 8; i++) buf_q.push_back(16'(i));
    exp_q.delete();
    mark_acc = 1'b1;
    mark_val = 1'b1;
    rec_xfer = 1'b1;
    en_v = 1'b1;
    wait_drain(100);
    rec_xfer = 1'b0;
    chk("first_latency", 32'(first_val_cyc - first_acc_cyc), 32'd2);
    chk("xfer_count8", 32'(xc_q.size()), 32'd8);
    if (xc_q.size() == 8) chk("back_to_back", 32'(xc_q[7] - xc_q[0]), 32'd7);
    chk("word_count8", {16'd0, word_count}, 32'd8);

    // Empty buffer: request held for 5+ cycles, then 0xBEEF arrives.
    step(3);
    chk("held_read", {31'd0, avm_read}, 32'd1);
    step(5);
    chk("held_read5", {31'd0, avm_read}, 32'd1);
    a0 = acc_total;
    x0 = xfer_total;
    buf_q.push_back(16'hBEEF);
    wait_drain(50);
    chk("beef_accepts", 32'(acc_total - a0), 32'd1);
    chk("beef_xfers", 32'(xfer_total - x0), 32'd1);

    // Sink stalled with 10 words available: exactly DEPTH buffered.
    rdy_pct = 0;
    x0 = xfer_total;
    for (int i = 0; i < 10; i++) buf_q.push_back(16'($urandom));
    step(20);
    chk("full_valid", {31'd0, st_valid}, 32'd1);
    chk("full_read_low", {31'd0, avm_read}, 32'd0);
    chk("full_outstanding", 32'(acc_total - xfer_total), 32'(DEPTH));
    chk("full_buf_left", 32'(buf_q.size()), 32'd6);
    rdy_pct = 100;
    wait_drain(100);
    chk("full_xfers", 32'(xfer_total - x0), 32'd10);

    // Enable dropped while a request is stalled.
    step(3);
    chk("pend_read", {31'd0, avm_read}, 32'd1);
    en_v = 1'b0;
    step(4);
    chk("pend_read_kept", {31'd0, avm_read}, 32'd1);
    a0 = acc_total;
    buf_q.push_back(16'h1234);
    wait_drain(50);
    chk("pend_accepts", 32'(acc_total - a0), 32'd1);
    for (int i = 0; i < 3; i++) buf_q.push_back(16'($urandom));
    step(10);
    chk("idle_no_reads", 32'(acc_total - a0), 32'd1);
    chk("idle_read_low", {31'd0, avm_read}, 32'd0);

    // Reset with 3 words buffered.
    rdy_pct = 0;
    en_v = 1'b1;
    step(12);
    chk("pre_rst_buffered", 32'(acc_total - xfer_total), 32'd3);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_st_valid", {31'd0, st_valid}, 32'd0);
    chk("mid_rst_word_count", {16'd0, word_count}, 32'd0);
    chk("mid_rst_avm_read", {31'd0, avm_read}, 32'd0);
    exp_q.delete();
    buf_q.delete();
    acc_total = 0;
    xfer_total = 0;
    pend_v = 1'b0;
    step(2);
    reset_n = 1'b1;
    rdy_pct = 100;
    step(2);

    // Randomized traffic with stalls, backpressure and enable toggling.
    stall_pct = 30;
    rdy_pct = 60;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(1) == 1 && buf_q.size() < 20) buf_q.push_back(16'($urandom));
      if ($urandom_range(99) < 3) en_v = !en_v;
      step(1);
    end
    en_v = 1'b1;
    stall_pct = 0;
    rdy_pct = 100;
    wait_drain(300);
    chk("random_balance", 32'(acc_total - xfer_total), 32'd0);

`ifdef M2S_DRAIN_LENGTH_LIMIT_EN
    // Length-limited session of 5 words out of 8.
    en_v = 1'b0;
    step(5);
    length_v = 16'd5;
    a0 = acc_total;
    x0 = xfer_total;
    for (int i = 0; i < 8; i++) buf_q.push_back(16'($urandom));
    en_v = 1'b1;
    begin
      int n = 0;
      while (!done && n < 100) begin
        step(1);
        n++;
      end
      chk("done_timeout", {31'd0, (n < 100)}, 32'd1);
    end
    step(3);
    chk("len_accepts", 32'(acc_total - a0), 32'd5);
    chk("len_xfers", 32'(xfer_total - x0), 32'd5);
    chk("len_buf_left", 32'(buf_q.size()), 32'd3);
    chk("len_done_held", {31'd0, done}, 32'd1);
    en_v = 1'b0;
    step(3);
    chk("len_done_clear", {31'd0, done}, 32'd0);
    length_v = 16'd0;
    a0 = acc_total;
    en_v = 1'b1;
    step(3);
    chk("len0_done", {31'd0, done}, 32'd1);
    chk("len0_no_reads", 32'(acc_total - a0), 32'd0);
    en_v = 1'b0;
    step(3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/m2s_drain_master.md
# m2s_drain_master

Avalon-MM read master that drains the 16-bit memory-to-stream FIFO buffer's read slave and re-emits the words as an Avalon-ST source with valid/ready backpressure. It sits between the buffer (waitrequest asserted while empty, read latency 1) and a streaming consumer such as a DMA or a pixel/sample sink. A small internal output FIFO absorbs the one-cycle read latency so that sustained throughput is one word per clock.

## Interface
- DATA_W, 16, data width of readdata and st_data.
- OUT_DEPTH, 4, output FIFO depth; power of two, ≥ 2.
- CNT_W, 16, width of word_count and length.

- wrclock  in  1  single clock; all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; high permits new read requests.
- avm_read  out  1  Avalon-MM read request to the buffer read slave.
- avm_readdata  in  DATA_W  read data, valid exactly 1 cycle after acceptance.
- avm_waitrequest  in  1  slave stall (buffer empty).
- st_data  out  DATA_W  stream data.
- st_valid  out  1  stream data valid.
- st_ready  in  1  sink accepts when st_valid & st_ready.
- word_count  out  CNT_W  count of completed stream transfers.
- length  in  CNT_W  transfer length (macro-enabled only).
- done  out  1  transfer complete (macro-enabled only).

## Operation
- Reset: avm_read=0, st_valid=0, st_data=0, word_count=0, done=0, FSM=IDLE, output FIFO empty, in-flight flag clear.
- Read accepted in cycle c when avm_read & ~avm_waitrequest; in-flight flag set for c+1; avm_readdata pushed into output FIFO at end of c+1.
- Issue rule: avm_read may rise in cycle c only if enable=1, FSM=RUN, and occupancy + in-flight + 1 ≤ OUT_DEPTH.
- Hold rule: once avm_read is high with avm_waitrequest high, avm_read stays high and unchanged until accepted, even if enable drops or the FIFO would otherwise restrict; enable only gates new requests.
- Back-to-back: avm_read stays high across consecutive accepts while the issue rule holds.
- Output FIFO: st_valid = occupancy≠0; st_data = head word (registered storage). Pop on st_valid & st_ready. Push and pop in the same cycle leave occupancy unchanged. Full FIFO is never overrun (guaranteed by the issue rule).
- word_count increments on each stream transfer; wraps 2^CNT_W−1 → 0.
- FSM: IDLE → RUN when enable=1; RUN → IDLE when enable=0 and no read is pending (in-flight data still drains to the stream). Without the macro, no other states.
- Reset mid-operation clears everything immediately; buffered and in-flight words are discarded.

## Timing
- Accept in cycle n → st_valid=1 in cycle n+2 (FIFO previously empty).
- Sustained rate: 1 word/cycle with avm_waitrequest=0 and st_ready=1 after a 2-cycle fill.
- st_ready low: at most OUT_DEPTH words buffered; avm_read deasserts within 1 cycle of the issue rule failing.
- st_valid/st_data are held stable while st_valid & ~st_ready.

## Configuration
- M2S_DRAIN_LENGTH_LIMIT_EN defined: length and done ports exist. length is sampled on IDLE→RUN; requests stop after length accepts; FSM RUN → DONE when word_count has advanced by length since start; done=1 in DONE until enable=0, then → IDLE, done=0. length=0 → DONE on the next cycle with no reads issued. word_count is not cleared per transfer.
- Undefined: no length/done ports; reads continue indefinitely while enable=1.

## Test plan
- Buffer preloaded with 0x0001..0x0008, st_ready=1, enable=1 → st_data 0x0001..0x0008 in order on consecutive cycles, first st_valid 2 cycles after first accept, word_count=8.
- Buffer empty (waitrequest=1) for 5 cycles then word 0xBEEF arrives → avm_read held high throughout, one st transfer of 0xBEEF.
- st_ready=0 with 10 words available → exactly 4 words buffered, avm_read low, no loss; st_ready=1 → all 10 words emitted in order.
- enable dropped while avm_read pending under waitrequest → read held until accepted, its word delivered, no further reads, FSM IDLE.
- Reset asserted with 3 words buffered → st_valid=0, word_count=0, avm_read=0 immediately.
- Macro enabled, length=5, 8 words available → exactly 5 accepts, done=1 after 5th transfer, 3 words remain in the buffer; length=0 → done next cycle with no reads.
